mmio_button_port: RTL and testbench
===================================

Name: mmio_button_port

Overview:
Memory-mapped input peripheral that answers CPU data-bus loads with debounced push-button state. It is the input-direction counterpart of the 7-segment display register: buttons are synchronised, debounced and press-latched, then read by the CPU over the same sel/ld/addr/data bus the data RAM uses. It sits beside the RAM responder in the tester top level and owns a small address window.

Parameters:
NBTN, 2, number of buttons (1..16)
DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles before the debounced level changes (1 ms at 50 MHz)
BASE, 12'h000, base address of the 4-word window (must be 4-aligned)

Ports:
clk  input  1  system clock; all state changes on posedge
res  input  1  asynchronous active-low reset
btn  input  NBTN  raw buttons, active-low, asynchronous to clk
sel  input  1  bus chip select
ld  input  1  1 = load (read), 0 = store (write); qualified by sel
addr  input  12  bus address
data_in  input  16  store data from CPU
data_out  output  16  load data to CPU, registered
hit  output  1  registered: previous-cycle access fell in the window
press_irq  output  1  level: any bit of EVENT set

Behaviour:
- Reset (res=0, async): sync flops, debounced level, counters, EVENT, COUNT, data_out, hit cleared to 0. Raw buttons are released (high) at reset, so debounced level starts "not pressed".
- Input path: btn inverted to active-high, two-flop synchroniser per bit. Per-button counter (width clog2(DEBOUNCE_CYCLES+1)): if sync bit == debounced bit, counter = 0; else counter increments; when counter reaches DEBOUNCE_CYCLES-1, debounced bit toggles and counter = 0. Latency raw edge -> debounced change = DEBOUNCE_CYCLES + 2 cycles. Glitches shorter than DEBOUNCE_CYCLES restart the count.
- Press event: debounced 0->1 sets EVENT[i] and increments COUNT. Release (1->0) sets nothing.
- Register window (word offsets, addr - BASE; upper data bits read 0):
  +0 LEVEL  RO  debounced levels [NBTN-1:0]
  +1 EVENT  R/W1C  sticky press flags; load returns value then clears the bits returned; store clears bits where data_in=1
  +2 COUNT  RW  16-bit press counter, wraps 16'hFFFF->0; store loads data_in
  +3 RAW  RO  synchronised (non-debounced) levels
- Bus timing: access sampled on posedge when sel=1 and addr in window. Load: data_out valid the following cycle, held until the next access. Any cycle with sel=0, or with sel=1 but addr outside the window: data_out <= 0 and hit <= 0, so the top level ORs data_out with the RAM data.
- Stores to LEVEL/RAW ignored. Stores never change data_out.
- Simultaneous events: new press in same cycle as EVENT clear (load or W1C) -> that bit ends 1. Press in same cycle as COUNT store -> COUNT = data_in + 1. Multiple presses in one cycle -> COUNT increments by the number of pressed bits.
- press_irq = |EVENT, combinational from the register.
- Reset mid-debounce discards partial counts; no event generated by reset release.

Test Plan:
(DEBOUNCE_CYCLES=4, NBTN=2, BASE=0 in bench)
- Reset: hold res=0, toggle btn -> data_out=0, hit=0, press_irq=0; release res, load +0 -> 16'h0000.
- Clean press: btn=2'b10 (btn0 pressed) held 10 cycles -> LEVEL=16'h0001 exactly 6 cycles after edge; press_irq=1; load +1 -> 16'h0001; second load +1 -> 16'h0000; COUNT=1.
- Bounce: btn0 low 3 cycles, high 1, low 3, high -> LEVEL stays 0, EVENT=0, COUNT=0; RAW load during the low phase -> 16'h0001.
- Race: new btn1 press debounces in the same cycle as a load of +1 holding EVENT=2'b01 -> data_out=16'h0001, EVENT then 2'b10.
- COUNT: store 16'hFFFF to +2, one press -> load +2 returns 16'h0000; store 16'h0003 to +1 clears both EVENT bits.
- Decode: load addr 12'h004 and sel=0 cycles -> data_out=0, hit=0; load +0 -> hit=1 next cycle.

Source files
------------

// File: rtl/mmio_button_port.sv
// Memory-mapped push-button input port: synchronises, debounces and press-latches
// NBTN active-low buttons and serves them over the CPU sel/ld/addr/data bus.
module mmio_button_port #(
   parameter int unsigned NBTN            = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter logic [11:0] BASE            = 12'h000
) (
   input  logic            clk,
   input  logic            res,
   input  logic [NBTN-1:0] btn,
   input  logic            sel,
   input  logic            ld,
   input  logic [11:0]     addr,
   input  logic [15:0]     data_in,
   output logic [15:0]     data_out,
   output logic            hit,
   output logic            press_irq
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      REG_LEVEL = 2'd0,
      REG_EVENT = 2'd1,
      REG_COUNT = 2'd2,
      REG_RAW   = 2'd3
   } reg_e;

   logic [NBTN-1:0] sync1, sync2;
   logic [NBTN-1:0] level, level_nxt;
   logic [NBTN-1:0] rise;
   logic [NBTN-1:0] event_q, event_nxt, event_clr;
   logic [CW-1:0]   cnt_q   [NBTN];
   logic [CW-1:0]   cnt_nxt [NBTN];
   logic [15:0]     count_q, count_nxt, count_base;
   logic [15:0]     rdata;
   logic            acc, rd, wr;
   reg_e            off;

   function automatic logic [15:0] popcnt(input logic [NBTN-1:0] v);
      logic [15:0] n;
      n = '0;
      for (int unsigned i = 0; i < NBTN; i++) begin
         n = n + 16'(v[i]);
      end
      return n;
   endfunction

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= ~btn;
         sync2 <= sync1;
      end
   end

   // Any sample agreeing with the debounced level restarts that button's count.
   always_comb begin
      level_nxt = level;
      cnt_nxt   = '{default: '0};
      for (int unsigned i = 0; i < NBTN; i++) begin
         if (sync2[i] != level[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               level_nxt[i] = ~level[i];
            end else begin
               cnt_nxt[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign rise = level_nxt & ~level;

   assign acc = sel && (addr[11:2] == BASE[11:2]);
   assign rd  = acc && ld;
   assign wr  = acc && !ld;
   assign off = reg_e'(addr[1:0]);

   always_comb begin
      rdata = '0;
      case (off)
         REG_LEVEL: rdata = 16'(level);
         REG_EVENT: rdata = 16'(event_q);
         REG_COUNT: rdata = count_q;
         REG_RAW:   rdata = 16'(sync2);
         default:   rdata = '0;
      endcase
   end

   // A press landing in the same cycle as a clear or store still takes effect.
   always_comb begin
      event_clr = '0;
      if (rd && off == REG_EVENT) event_clr = event_q;
      if (wr && off == REG_EVENT) event_clr = data_in[NBTN-1:0];
      event_nxt  = (event_q & ~event_clr) | rise;
      count_base = (wr && off == REG_COUNT) ? data_in : count_q;
      count_nxt  = count_base + popcnt(rise);
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         level   <= '0;
         cnt_q   <= '{default: '0};
         event_q <= '0;
         count_q <= '0;
      end else begin
         level   <= level_nxt;
         cnt_q   <= cnt_nxt;
         event_q <= event_nxt;
         count_q <= count_nxt;
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         data_out <= '0;
         hit      <= 1'b0;
      end else if (acc) begin
         hit <= 1'b1;
         if (ld) data_out <= rdata;
      end else begin
         data_out <= '0;
         hit      <= 1'b0;
      end
   end

   assign press_irq = |event_q;

endmodule

// File: tb/tb_mmio_button_port.sv
// Self-checking bench for mmio_button_port: directed vector table, hand-written
// corner sequences and randomized traffic against a window-based reference model.
module tb_mmio_button_port;

   localparam int unsigned NB = 2;
   localparam int unsigned D  = 4;

   logic          clk = 1'b0;
   logic          res = 1'b1;
   logic [NB-1:0] btn = '1;
   logic          sel = 1'b0;
   logic          ld = 1'b0;
   logic [11:0]   addr = '0;
   logic [15:0]   data_in = '0;
   logic [15:0]   data_out;
   logic          hit;
   logic          press_irq;

   int ntests = 0;
   int nfail  = 0;

   mmio_button_port #(
      .NBTN(NB),
      .DEBOUNCE_CYCLES(D),
      .BASE(12'h000)
   ) dut (
      .clk(clk),
      .res(res),
      .btn(btn),
      .sel(sel),
      .ld(ld),
      .addr(addr),
      .data_in(data_in),
      .data_out(data_out),
      .hit(hit),
      .press_irq(press_irq)
   );

   always #5 clk = ~clk;

   // Reference model: h[k] is the pressed pattern k edges back; a level flips
   // once the D samples seen through the 2-flop delay all disagree with it.
   logic [NB-1:0] h [8];
   logic [NB-1:0] m_deb = '0;
   logic [NB-1:0] m_ev  = '0;
   logic [15:0]   m_cnt = '0;
   logic [15:0]   m_do  = '0;
   logic          m_hit = 1'b0;

   task automatic model_edge();
      logic [NB-1:0] nd, rise, clr;
      logic [15:0]   rv, ncnt;
      logic          win, flip;
      if (!res) begin
         for (int k = 0; k < 8; k++) h[k] = '0;
         m_deb = '0; m_ev = '0; m_cnt = '0; m_do = '0; m_hit = 1'b0;
         return;
      end
      for (int k = 7; k > 0; k--) h[k] = h[k-1];
      h[0] = ~btn;
      nd = m_deb;
      for (int i = 0; i < NB; i++) begin
         flip = 1'b1;
         for (int j = 2; j <= D + 1; j++) if (h[j][i] == m_deb[i]) flip = 1'b0;
         if (flip) nd[i] = ~m_deb[i];
      end
      rise = nd & ~m_deb;
      win  = sel && (addr[11:2] == 10'd0);
      case (addr[1:0])
         2'd0:    rv = 16'(m_deb);
         2'd1:    rv = 16'(m_ev);
         2'd2:    rv = m_cnt;
         default: rv = 16'(h[2]);
      endcase
      clr = '0;
      if (win && addr[1:0] == 2'd1) clr = ld ? m_ev : data_in[NB-1:0];
      ncnt = (win && !ld && addr[1:0] == 2'd2) ? data_in : m_cnt;
      ncnt = ncnt + 16'($countones(rise));
      if (win) begin
         m_hit = 1'b1;
         if (ld) m_do = rv;
      end else begin
         m_hit = 1'b0;
         m_do  = '0;
      end
      m_ev  = (m_ev & ~clr) | rise;
      m_cnt = ncnt;
      m_deb = nd;
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      chk("model_data_out", data_out, m_do);
      chk("model_hit", 16'(hit), 16'(m_hit));
      chk("model_irq", 16'(press_irq), 16'(|m_ev));
   endtask

   task automatic apply(input logic [NB-1:0] b, input logic s, input logic l,
                        input logic [11:0] a, input logic [15:0] d);
      btn = b; sel = s; ld = l; addr = a; data_in = d;
   endtask

   task automatic dir(input string nm, input logic [NB-1:0] b, input logic s,
                      input logic l, input logic [11:0] a, input logic [15:0] d,
                      input logic [15:0] edo, input logic eh, input logic ei);
      apply(b, s, l, a, d);
      step();
      chk({nm, "/data_out"}, data_out, edo);
      chk({nm, "/hit"}, 16'(hit), 16'(eh));
      chk({nm, "/irq"}, 16'(press_irq), 16'(ei));
   endtask

   task automatic idle(input int n, input logic [NB-1:0] b);
      for (int k = 0; k < n; k++) begin
         apply(b, 1'b0, 1'b0, 12'h000, 16'h0000);
         step();
      end
   endtask

   typedef struct {
      logic [NB-1:0] b;
      logic          s;
      logic          l;
      logic [11:0]   a;
      logic [15:0]   d;
      logic [15:0]   edo;
      logic          eh;
      logic          ei;
   } vec_t;

   function automatic vec_t v(input logic [NB-1:0] b, input logic s, input logic l,
                              input logic [11:0] a, input logic [15:0] d,
                              input logic [15:0] edo, input logic eh, input logic ei);
      vec_t r;
      r.b = b; r.s = s; r.l = l; r.a = a; r.d = d; r.edo = edo; r.eh = eh; r.ei = ei;
      return r;
   endfunction

   vec_t tbl [17];

   initial begin
      // Clean press of btn0, readback of every register, decode and store-hold checks.
      tbl[0]  = v(2'b10, 0, 0, 12'h000, 16'h0000, 16'h0000, 0, 0);
      tbl[1]  = v(2'b10, 1, 1, 12'h003, 16'h0000, 16'h0000, 1, 0);
      tbl[2]  = v(2'b10, 1, 1, 12'h003, 16'h0000, 16'h0001, 1, 0);
      tbl[3]  = v(2'b10, 0, 0, 12'h000, 16'h0000, 16'h0000, 0, 0);
      tbl[4]  = v(2'b10, 1, 1, 12'h000, 16'h0000, 16'h0000, 1, 0);
      tbl[5]  = v(2'b10, 1, 1, 12'h000, 16'h0000, 16'h0000, 1, 1);
      tbl[6]  = v(2'b10, 1, 1, 12'h000, 16'h0000, 16'h0001, 1, 1);
      tbl[7]  = v(2'b10, 1, 1, 12'h002, 16'h0000, 16'h0001, 1, 1);
      tbl[8]  = v(2'b10, 1, 1, 12'h001, 16'h0000, 16'h0001, 1, 0);
      tbl[9]  = v(2'b10, 1, 1, 12'h001, 16'h0000, 16'h0000, 1, 0);
      tbl[10] = v(2'b10, 1, 0, 12'h002, 16'h00FF, 16'h0000, 1, 0);
      tbl[11] = v(2'b10, 1, 1, 12'h002, 16'h0000, 16'h00FF, 1, 0);
      tbl[12] = v(2'b10, 1, 1, 12'h004, 16'h0000, 16'h0000, 0, 0);
      tbl[13] = v(2'b10, 0, 1, 12'h000, 16'h0000, 16'h0000, 0, 0);
      tbl[14] = v(2'b10, 1, 1, 12'h002, 16'h0000, 16'h00FF, 1, 0);
      tbl[15] = v(2'b10, 1, 0, 12'h000, 16'hFFFF, 16'h00FF, 1, 0);
      tbl[16] = v(2'b11, 0, 0, 12'h000, 16'h0000, 16'h0000, 0, 0);

      for (int k = 0; k < 8; k++) h[k] = '0;

      // Reset held while buttons wiggle.
      #2 res = 1'b0;
      for (int k = 0; k < 4; k++) begin
         dir("reset_hold", NB'($urandom), 1, 1, 12'h000, 16'h0000, 16'h0000, 0, 0);
      end
      res = 1'b1;
      idle(2, 2'b11);
      dir("reset_level", 2'b11, 1, 1, 12'h000, 16'h0000, 16'h0000, 1, 0);

      for (int k = 0; k < 17; k++) begin
         dir($sformatf("tbl%0d", k), tbl[k].b, tbl[k].s, tbl[k].l, tbl[k].a,
             tbl[k].d, tbl[k].edo, tbl[k].eh, tbl[k].ei);
      end
      idle(8, 2'b11);

      // Bounce: two 3-cycle lows never reach the 4-cycle threshold.
      dir("bounce_a", 2'b10, 0, 0, 12'h000, 16'h0000, 16'h0000, 0, 0);
      dir("bounce_b", 2'b10, 0, 0, 12'h000, 16'h0000, 16'h0000, 0, 0);
      dir("bounce_raw", 2'b10, 1, 1, 12'h003, 16'h0000, 16'h0001, 1, 0);
      idle(1, 2'b11);
      idle(3, 2'b10);
      idle(8, 2'b11);
      dir("bounce_level", 2'b11, 1, 1, 12'h000, 16'h0000, 16'h0000, 1, 0);
      dir("bounce_event", 2'b11, 1, 1, 12'h001, 16'h0000, 16'h0000, 1, 0);
      dir("bounce_count", 2'b11, 1, 1, 12'h002, 16'h0000, 16'h00FF, 1, 0);

      // Race: btn1 debounces on the very edge that reads/clears EVENT=01.
      idle(7, 2'b10);
      idle(5, 2'b00);
      dir("race_read", 2'b00, 1, 1, 12'h001, 16'h0000, 16'h0001, 1, 1);
      dir("race_after", 2'b00, 1, 1, 12'h001, 16'h0000, 16'h0002, 1, 0);
      idle(8, 2'b11);
      dir("race_count", 2'b11, 1, 1, 12'h002, 16'h0000, 16'h0101, 1, 0);

      // COUNT wrap and W1C of both EVENT bits.
      dir("wrap_press", 2'b10, 0, 0, 12'h000, 16'h0000, 16'h0000, 0, 0);
      idle(1, 2'b10);
      dir("wrap_store", 2'b10, 1, 0, 12'h002, 16'hFFFF, 16'h0000, 1, 0);
      idle(4, 2'b10);
      dir("wrap_read", 2'b10, 1, 1, 12'h002, 16'h0000, 16'h0000, 1, 1);
      dir("w1c_both", 2'b10, 1, 0, 12'h001, 16'h0003, 16'h0000, 1, 0);
      idle(8, 2'b11);

      // Press on the same edge as a COUNT store.
      idle(5, 2'b10);
      dir("store_press", 2'b10, 1, 0, 12'h002, 16'h1234, 16'h0000, 1, 1);
      dir("store_press_cnt", 2'b10, 1, 1, 12'h002, 16'h0000, 16'h1235, 1, 1);
      dir("store_press_ev", 2'b10, 1, 1, 12'h001, 16'h0000, 16'h0001, 1, 0);
      idle(8, 2'b11);

      // Two presses debouncing together.
      idle(6, 2'b00);
      dir("multi_ev", 2'b00, 1, 1, 12'h001, 16'h0000, 16'h0003, 1, 0);
      dir("multi_cnt", 2'b00, 1, 1, 12'h002, 16'h0000, 16'h1237, 1, 0);
      idle(8, 2'b11);

      // Randomized traffic with slow-changing buttons and occasional reset.
      for (int k = 0; k < 800; k++) begin
         logic [NB-1:0] b;
         b = btn;
         if ($urandom_range(0, 5) == 0) b[$urandom_range(0, NB-1)] = ~b[$urandom_range(0, NB-1)];
         if ($urandom_range(0, 199) == 0) res = 1'b0;
         apply(b, ($urandom_range(0, 3) != 0), 1'($urandom), 12'($urandom_range(0, 7)),
               16'($urandom));
         step();
         res = 1'b1;
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
